// File: rtl/mem_pass_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_pass_sequencer_if
//   Bundles the pass-control and banked-memory address signals of the
//   mem_pass_sequencer.
//
//   master : stage-controller view (drives start and the pass configuration,
//            observes status, addresses and datapath strobes)
//   slave  : sequencer view (the mem_pass_sequencer itself)
//
//   start       pass request
//   rd_base     first row to read
//   wr_base     first row to write
//   stride      row increment per element
//   len         rows in the pass, 0..2^AW (larger values are clamped)
//   busy        pass in progress
//   done        one-cycle completion pulse
//   addr_read   per-bank read address, N identical AW-bit lanes
//   addr_write  per-bank write address, N identical AW-bit lanes
//   we          per-bank write enable, all bits identical
//   dp_in_valid memory dout holds the current element
//   dp_in_last  marks the final dp_in_valid beat
// -----------------------------------------------------------------------------
interface mem_pass_sequencer_if #(
    parameter int N  = 257,
    parameter int AW = 8
);
    logic              start;
    logic [AW-1:0]     rd_base;
    logic [AW-1:0]     wr_base;
    logic [AW-1:0]     stride;
    logic [AW:0]       len;
    logic              busy;
    logic              done;
    logic [N*AW-1:0]   addr_read;
    logic [N*AW-1:0]   addr_write;
    logic [N-1:0]      we;
    logic              dp_in_valid;
    logic              dp_in_last;

    modport master (
        output start, rd_base, wr_base, stride, len,
        input  busy, done, addr_read, addr_write, we, dp_in_valid, dp_in_last
    );

    modport slave (
        input  start, rd_base, wr_base, stride, len,
        output busy, done, addr_read, addr_write, we, dp_in_valid, dp_in_last
    );
endinterface

// File: rtl/mem_pass_sequencer.sv
// -----------------------------------------------------------------------------
// mem_pass_sequencer
//   Runs one read-compute-write pass over the banked NTT coefficient memory.
//   One row is read per cycle (same address on every bank); a valid/last strobe
//   follows the read data into the butterfly datapath, and the matching write
//   address plus write enables come out once the datapath latency has elapsed.
//   A single-cycle done pulse closes the pass.
//
//   clk  system clock
//   rst  synchronous active-high reset; aborts a running pass
//   bus  mem_pass_sequencer_if.slave (start/config in, status/addresses out)
//
//   With start sampled at cycle 0, element k is read at cycle 1+k, presented
//   on dp_in_valid at 1+k+RD_LAT and written at 1+k+RD_LAT+PIPE_LAT.
// -----------------------------------------------------------------------------
module mem_pass_sequencer #(
    parameter int N        = 257,
    parameter int AW       = 8,
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 4
) (
    input logic                 clk,
    input logic                 rst,
    mem_pass_sequencer_if.slave bus
);

    // Distance from the issue register to the write register; the stages in
    // between form the delay line. The write register itself is the last hop.
    localparam int D    = RD_LAT + PIPE_LAT;
    localparam int LINE = D - 1;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    // One element in flight: its write row travels with its valid/last flags,
    // so nothing is recomputed at write time.
    typedef struct packed {
        logic          valid;
        logic          last;
        logic [AW-1:0] waddr;
    } elem_t;

    state_t        state, state_next;
    logic [AW-1:0] stride_q;
    logic [AW:0]   cnt_q;        // elements still to issue after the current one
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] wr_addr_q;
    logic          we_q;
    logic          busy_q;
    logic          done_q;
    elem_t         iss_q;        // element issued this cycle
    elem_t         line_q [LINE];

    logic [AW:0]   len_c;
    logic          load, issue, last_d, busy_d, done_d, pending;

    assign len_c = bus.len[AW] ? MAX_LEN : bus.len;

    // Any element still travelling towards the write register.
    always_comb begin
        pending = iss_q.valid;
        for (int i = 0; i < LINE; i++) begin
            pending = pending | line_q[i].valid;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (len_c == '0) ? FINISH : ISSUE;
            ISSUE:   if (cnt_q == '0) state_next = DRAIN;
            DRAIN:   if (!pending) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values of registered outputs) ----
    always_comb begin
        load   = 1'b0;
        issue  = 1'b0;
        last_d = 1'b0;
        case (state)
            IDLE: begin
                // Capture and the first read happen on the same edge.
                if (bus.start && (len_c != '0)) begin
                    load   = 1'b1;
                    issue  = 1'b1;
                    last_d = (len_c == ONE);
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    issue  = 1'b1;
                    last_d = (cnt_q == ONE);
                end
            end
            default: ;
        endcase
        busy_d = (state_next == ISSUE) || (state_next == DRAIN);
        done_d = (state_next == FINISH);
    end

    // ---------------- Address generation and delay line ----------------
    always_ff @(posedge clk) begin
        // NOTE: the delay line is a handful of flops, not a RAM, so it is
        // cleared on reset; an aborted pass must leave no write in flight.
        if (rst) begin
            stride_q  <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iss_q     <= '0;
            for (int i = 0; i < LINE; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every stage shifts on the
            // old value of its neighbour, independent of statement order.
            if (load) begin
                stride_q    <= bus.stride;
                cnt_q       <= len_c - ONE;
                rd_addr_q   <= bus.rd_base;
                iss_q.waddr <= bus.wr_base;
            end else if (issue) begin
                cnt_q       <= cnt_q - ONE;
                rd_addr_q   <= rd_addr_q + stride_q;     // wraps modulo 2^AW
                iss_q.waddr <= iss_q.waddr + stride_q;
            end
            iss_q.valid <= issue;
            iss_q.last  <= last_d;

            line_q[0] <= iss_q;
            for (int i = 1; i < LINE; i++) begin
                line_q[i] <= line_q[i-1];
            end

            // Write address holds its last value between writes.
            we_q <= line_q[LINE-1].valid;
            if (line_q[LINE-1].valid) begin
                wr_addr_q <= line_q[LINE-1].waddr;
            end

            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.addr_read   = {N{rd_addr_q}};
    assign bus.addr_write  = {N{wr_addr_q}};
    assign bus.we          = {N{we_q}};
    assign bus.dp_in_valid = line_q[RD_LAT-1].valid;
    assign bus.dp_in_last  = line_q[RD_LAT-1].last;

endmodule

// File: tb/tb_mem_pass_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_pass_sequencer
//   Directed bench for mem_pass_sequencer. Each pass is driven cycle by cycle
//   from cycle 0 (start sampled); outputs are checked 1 ns after each rising
//   edge against the cycle timing of the pass, and the observed read/write rows
//   and done cycle are then compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_pass_sequencer;

    localparam int N        = 257;
    localparam int AW       = 8;
    localparam int RD_LAT   = 1;
    localparam int PIPE_LAT = 4;
    localparam int D        = RD_LAT + PIPE_LAT;

    logic clk;
    logic rst;

    mem_pass_sequencer_if #(.N(N), .AW(AW)) bus ();

    mem_pass_sequencer #(
        .N(N), .AW(AW), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Observations of the most recent pass.
    logic [7:0] rd_seen [256];
    logic [7:0] wr_seen [256];
    int         we_cnt;
    int         busy_cnt;
    int         done_at;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pass and check every cycle. inj_a/inj_b: cycles at which a
    // stray start is pulsed (-1 = none). rst_at: cycle during which rst is
    // held (-1 = none); from the next cycle everything must read zero.
    task automatic run_pass(input string tag, input logic [7:0] rb, input logic [7:0] wb,
                            input logic [7:0] st, input logic [8:0] ln,
                            input int inj_a, input int inj_b, input int rst_at);
        int         lc, done_c, end_c, k;
        logic       aborted, uniform;
        logic       e_busy, e_done, e_dv, e_dl, e_we;
        logic [7:0] e_addr;
        lc     = (ln > 9'd256) ? 256 : int'(ln);
        done_c = (lc == 0) ? 1 : lc + D + 1;
        end_c  = done_c + 2;
        we_cnt = 0; busy_cnt = 0; done_at = -1;
        for (int i = 0; i < 256; i++) begin
            rd_seen[i] = 8'hxx;
            wr_seen[i] = 8'hxx;
        end

        // cycle 0: request
        bus.rd_base = rb; bus.wr_base = wb; bus.stride = st; bus.len = ln;
        bus.start = 1'b1;
        tick();
        // Scrambled config from here on: must have no effect on this pass.
        bus.start = 1'b0;
        bus.rd_base = ~rb; bus.wr_base = ~wb; bus.stride = st + 8'd1; bus.len = 9'd5;

        for (int c = 1; c <= end_c; c++) begin
            bus.start = (c == inj_a) || (c == inj_b);
            rst       = (c == rst_at);
            aborted   = (rst_at > 0) && (c > rst_at);
            e_busy = !aborted && (lc > 0) && (c <= lc + D);
            e_done = !aborted && (c == done_c);
            e_dv   = !aborted && (lc > 0) && (c >= 1 + RD_LAT) && (c <= lc + RD_LAT);
            e_dl   = !aborted && (lc > 0) && (c == lc + RD_LAT);
            e_we   = !aborted && (lc > 0) && (c >= 1 + D) && (c <= lc + D);

            check({tag, "_busy"},  bus.busy,        e_busy);
            check({tag, "_done"},  bus.done,        e_done);
            check({tag, "_dv"},    bus.dp_in_valid, e_dv);
            check({tag, "_dlast"}, bus.dp_in_last,  e_dl);
            check({tag, "_we"},    bus.we[0],       e_we);
            uniform = (bus.addr_read  === {N{bus.addr_read[AW-1:0]}})  &&
                      (bus.addr_write === {N{bus.addr_write[AW-1:0]}}) &&
                      (bus.we         === {N{bus.we[0]}});
            check({tag, "_lanes"}, uniform, 1'b1);

            if (aborted) begin
                check({tag, "_rd_rst"}, bus.addr_read[AW-1:0],  8'h00);
                check({tag, "_wr_rst"}, bus.addr_write[AW-1:0], 8'h00);
            end else if (lc > 0) begin
                k      = (c < lc) ? c - 1 : lc - 1;
                e_addr = 8'(int'(rb) + k * int'(st));
                check({tag, "_rd_addr"}, bus.addr_read[AW-1:0], e_addr);
                if (c >= 1 + D) begin
                    k      = (c < lc + D) ? c - 1 - D : lc - 1;
                    e_addr = 8'(int'(wb) + k * int'(st));
                    check({tag, "_wr_addr"}, bus.addr_write[AW-1:0], e_addr);
                end
            end

            if (c >= 1 && c <= lc) rd_seen[c-1] = bus.addr_read[AW-1:0];
            if (bus.we[0]) begin
                if (we_cnt < 256) wr_seen[we_cnt] = bus.addr_write[AW-1:0];
                we_cnt++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = c;
            tick();
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.rd_base = '0; bus.wr_base = '0; bus.stride = '0; bus.len = '0;
        tick();
        tick();
        // Reset state
        check("rst_busy",  bus.busy,        1'b0);
        check("rst_done",  bus.done,        1'b0);
        check("rst_we",    bus.we === '0,   1'b1);
        check("rst_dv",    bus.dp_in_valid, 1'b0);
        check("rst_dlast", bus.dp_in_last,  1'b0);
        check("rst_rd",    bus.addr_read  === '0, 1'b1);
        check("rst_wr",    bus.addr_write === '0, 1'b1);
        rst = 1'b0;
        tick();

        // Basic pass
        run_pass("basic", 8'h10, 8'h80, 8'd1, 9'd3, -1, -1, -1);
        check("basic_done_at", done_at,  9);
        check("basic_we_cnt",  we_cnt,   3);
        check("basic_busy_cnt", busy_cnt, 8);
        check("basic_rd0", rd_seen[0], 8'h10);
        check("basic_rd2", rd_seen[2], 8'h12);
        check("basic_wr0", wr_seen[0], 8'h80);
        check("basic_wr2", wr_seen[2], 8'h82);

        // Stray starts at cycle 2 and in the done cycle are ignored
        run_pass("inj", 8'h10, 8'h80, 8'd1, 9'd3, 2, 9, -1);
        check("inj_done_at", done_at, 9);
        check("inj_we_cnt",  we_cnt,  3);
        check("inj_wr1",     wr_seen[1], 8'h81);

        // Wrap with stride 3
        run_pass("wrap", 8'hFE, 8'hFF, 8'd3, 9'd3, -1, -1, -1);
        check("wrap_rd0", rd_seen[0], 8'hFE);
        check("wrap_rd1", rd_seen[1], 8'h01);
        check("wrap_rd2", rd_seen[2], 8'h04);
        check("wrap_wr0", wr_seen[0], 8'hFF);
        check("wrap_wr1", wr_seen[1], 8'h02);
        check("wrap_wr2", wr_seen[2], 8'h05);

        // len = 0
        run_pass("len0", 8'h20, 8'h40, 8'd1, 9'd0, -1, -1, -1);
        check("len0_done_at",  done_at,  1);
        check("len0_we_cnt",   we_cnt,   0);
        check("len0_busy_cnt", busy_cnt, 0);

        // Full depth
        run_pass("full", 8'h00, 8'h00, 8'd1, 9'd256, -1, -1, -1);
        check("full_done_at", done_at, 262);
        check("full_we_cnt",  we_cnt,  256);
        check("full_wr0",     wr_seen[0],   8'h00);
        check("full_wr255",   wr_seen[255], 8'hFF);
        check("full_rd255",   rd_seen[255], 8'hFF);

        // len = 300 clamps to 256
        run_pass("clamp", 8'h00, 8'h00, 8'd1, 9'd300, -1, -1, -1);
        check("clamp_done_at", done_at, 262);
        check("clamp_we_cnt",  we_cnt,  256);
        check("clamp_wr255",   wr_seen[255], 8'hFF);

        // Reset during cycle 4 of the basic pass
        run_pass("abort", 8'h10, 8'h80, 8'd1, 9'd3, -1, -1, 4);
        check("abort_done_at", done_at, -1);
        check("abort_we_cnt",  we_cnt,  0);

        // Fresh start reproduces the basic pass
        run_pass("again", 8'h10, 8'h80, 8'd1, 9'd3, -1, -1, -1);
        check("again_done_at", done_at, 9);
        check("again_we_cnt",  we_cnt,  3);
        check("again_wr2",     wr_seen[2], 8'h82);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_pass_sequencer.md
Name: mem_pass_sequencer

Overview:
- Sequences one full read–compute–write pass over the banked NTT coefficient memory (N parallel simple-dual-port banks, 8-bit row address, 32-bit words).
- Issues the same row address to every bank on the read port and aligns a valid strobe to the returning data for the butterfly/twiddle datapath.
- Issues the write-back address and write enables once the datapath pipeline latency has elapsed.
- Signals completion to the top-level NTT stage controller with a single-cycle done pulse.

Parameters:
- N, 257, number of memory banks; width of the we/addr vectors.
- AW, 8, row address width; bank depth is 2^AW.
- RD_LAT, 1, memory read latency in cycles, from addr_read to dout valid.
- PIPE_LAT, 4, datapath latency in cycles, from dp_in_valid to din valid.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pass request; sampled only when idle.
- rd_base  in  AW  first row to read.
- wr_base  in  AW  first row to write.
- stride  in  AW  row increment per element.
- len  in  AW+1  number of rows in the pass, 0..2^AW.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when the pass completes.
- addr_read  out  N*AW  per-bank read address; all lanes identical.
- addr_write  out  N*AW  per-bank write address; all lanes identical.
- we  out  N  per-bank write enable; all bits identical.
- dp_in_valid  out  1  memory dout holds element k this cycle.
- dp_in_last  out  1  qualifies the final dp_in_valid beat.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, we=0, dp_in_valid=0, dp_in_last=0, addr_read=0, addr_write=0. The FSM returns to IDLE and all delay lines clear.
- FSM states:
  - IDLE: start=1 and done=0 captures rd_base, wr_base, stride and len. Go to ISSUE; if the captured len=0, go to FINISH instead.
  - ISSUE: one read per cycle. Element k (k=0..len-1) drives addr_read = rd_base + k*stride mod 2^AW. After the last issue, go to DRAIN.
  - DRAIN: wait until the delay lines hold no pending writes.
  - FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Timing, with start sampled at cycle 0:
  - Read of element k issued at cycle 1+k.
  - dp_in_valid at cycle 1+k+RD_LAT; dp_in_last on k=len-1.
  - we=all-ones with addr_write = wr_base + k*stride mod 2^AW at cycle 1+k+RD_LAT+PIPE_LAT.
  - done at cycle len+RD_LAT+PIPE_LAT+1.
  - busy=1 from cycle 1 through the cycle of the last we.
- len=0: no reads and no writes; busy stays 0; done pulses at cycle 1.
- len > 2^AW is clamped to 2^AW.
- Address arithmetic wraps modulo 2^AW.
- Implementation: write address and valid travel through shift registers of depth RD_LAT and PIPE_LAT alongside the element index. No recomputation is allowed.
- addr_read and addr_write hold their last value when not issuing. we is 0 whenever no write is due.
- start while busy=1 or done=1 is ignored, with no queuing.
- Changes on rd_base, wr_base, stride or len after capture have no effect until the next accepted start.
- rst mid-pass aborts immediately: next cycle we=0, busy=0, and no done pulse. Rows already written remain; completing or undoing them is not required.
- Row uniqueness (odd stride or len ≤ period) and read-before-write ordering for in-place passes are the caller's responsibility. The block performs no hazard checks.

Test Plan:
- Basic pass (rd_base=0x10, wr_base=0x80, stride=1, len=3, start at cycle 0):
  - addr_read = 0x10, 0x11, 0x12 at cycles 1–3.
  - dp_in_valid at cycles 2–4, with dp_in_last at cycle 4.
  - we=all-ones at cycles 6–8 with addr_write = 0x80, 0x81, 0x82.
  - done at cycle 9; busy high for cycles 1–8.
- Wrap/stride (rd_base=0xFE, wr_base=0xFF, stride=3, len=3):
  - addr_read = 0xFE, 0x01, 0x04.
  - addr_write = 0xFF, 0x02, 0x05.
- len=0 start: done pulse at cycle 1; we, busy and dp_in_valid never asserted.
- Full depth (len=256, stride=1, rd_base=wr_base=0):
  - 256 consecutive we cycles covering rows 0x00–0xFF.
  - done at cycle 262.
  - len=300 produces the same behaviour (clamped).
- start pulsed at cycle 2 of a running len=3 pass with different bases:
  - Ignored; outputs are identical to the basic pass.
  - A start in the done cycle is also ignored.
- rst asserted at cycle 4 of the basic pass:
  - From cycle 5: we=0, busy=0, done=0, addresses=0.
  - No later writes or done.
  - A fresh start afterwards reproduces the basic pass timing.
